mult_share_arb: RTL
===================

# mult_share_arb

Round-robin scheduler that shares one 18-bit Q10.8 Booth multiplier among several requesters, such as neuron-update or synapse-weight units. It accepts operand pairs over valid/ready handshakes and issues at most one pair per cycle to the multiplier. It tracks each issued operation through the multiplier's fixed latency and returns the product tagged with the requester's index. It sits between the requesting compute units and the single shared multiplier instance.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- DATA_W, 18: operand and product width.
- MUL_LAT, 1: register stages inside the multiplier, 1..4.
- ID_W, derived as clog2(NUM_REQ): requester tag width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  grant enable; low blocks new grants.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_m  in  NUM_REQ*DATA_W  multiplicands; slice i belongs to requester i.
- req_r  in  NUM_REQ*DATA_W  multipliers; slice i belongs to requester i.
- req_ready  out  NUM_REQ  one-hot grant, or all zero.
- mul_m  out  DATA_W  registered operand to multiplier M.
- mul_r  out  DATA_W  registered operand to multiplier R.
- mul_product  in  DATA_W  multiplier result, already scaled as prod[25:8].
- resp_valid  out  1  result-valid pulse.
- resp_id  out  ID_W  index of the requester that owns resp_product.
- resp_product  out  DATA_W  result.
- busy  out  1  at least one operation is in flight.

## Operation
Arbitration:
- A rotating pointer ptr (reset value 0) gives ptr highest priority.
- The grant goes to the first i with req_valid[i] set, searching ptr, ptr+1, … mod NUM_REQ.
- req_ready is combinational from req_valid, ptr and en. It is at most one-hot and is all zero when en=0 or no request is pending.

Handshake:
- A transfer happens when req_valid[i] && req_ready[i].
- A requester holds req_m and req_r stable, with valid high, until it sees ready.
- After a grant to index g, ptr becomes (g+1) mod NUM_REQ. With no grant, ptr is unchanged.

Issue:
- On a grant, mul_m and mul_r load the granted slices.
- Otherwise they hold their previous values.

Tracking:
- A shift pipe of 1+MUL_LAT entries carries {valid, id}.
- Each grant pushes {1, g}; each cycle without a grant pushes {0, x}.

Response:
- resp_valid and resp_id are driven from the pipe tail.
- resp_product is mul_product passed through combinationally.
- Responses have no backpressure; the owning requester must accept in the cycle resp_valid is high.
- resp_product is don't-care when resp_valid=0.

Other rules:
- busy is the OR of all pipe valid bits.
- en=0 only stops new grants; operations already in flight complete normally.
- Arithmetic: no sign extension or rescaling is done in this block; the product passes through bit-exact.

## Timing
Reset values:
- req_ready=0, mul_m=0, mul_r=0, resp_valid=0, resp_id=0, busy=0, ptr=0, pipe cleared.

Latency and throughput:
- Grant in cycle t puts operands on mul_m/mul_r in t+1.
- resp_valid is high in cycle t+1+MUL_LAT, i.e. t+2 for MUL_LAT=1.
- Throughput is one operation per cycle. Back-to-back grants produce back-to-back responses in grant order.

Boundary conditions:
- When several requests are valid together, only one is granted. The losers keep valid high; their wait is bounded by NUM_REQ-1 cycles.
- If a requester drops valid without a grant, nothing is issued.
- Reset asserted mid-operation discards all in-flight operations. No resp_valid appears for them, either during reset or in the first cycle after it is released. The multiplier shares the same reset.
- Pointer wrap-around: a grant to NUM_REQ-1 sets ptr to 0.

## Structure
Shared package mult_arb_pkg holds:
- DATA_W, default NUM_REQ, MUL_LAT, ID_W.
- The Q10.8 format constants: FRAC_BITS=8 and ONE=18'h00100.

Sub-module rr_arbiter (NUM_REQ) contains:
- The pointer register and the cyclic priority search.
- Outputs: a one-hot grant and its binary index.

The top level holds the operand registers, the tracking pipe and the response outputs.

## Test plan
- Single request: requester 2 sends M=18'h00100, R=18'h00200 at t → resp_valid at t+2 with resp_id=2, resp_product=18'h00200.
- Signed operand: M=18'h3FF00 (-1.0), R=18'h00200 → resp_product=18'h3FE00 (-2.0).
- All four requesters valid continuously from reset → grants in order 0,1,2,3,0 on consecutive cycles. Responses arrive on consecutive cycles, each id matching its operands (M=i+1, R=ONE).
- Fairness after wrap: only requesters 3 and 0 valid with ptr=3 → grant 3, then 0, then 3.
- en=0 while requester 1 is valid and one operation is in flight → no req_ready asserted; the in-flight response still arrives. Requester 1 is granted the cycle after en=1.
- Reset asserted one cycle after a grant → no resp_valid at any point, busy=0 after reset, and the first grant after release goes to requester 0.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// Shared constants for the multiplier-sharing scheduler: default geometry and
// the Q10.8 fixed-point format used by the requesters.
package mult_arb_pkg;

    localparam int unsigned MA_DATA_W  = 18;
    localparam int unsigned MA_NUM_REQ = 4;
    localparam int unsigned MA_MUL_LAT = 1;
    localparam int unsigned MA_ID_W    = $clog2(MA_NUM_REQ);

    localparam int unsigned            FRAC_BITS = 8;
    localparam logic [MA_DATA_W-1:0]   ONE       = 18'h00100;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: rotating priority pointer, one-hot grant plus its index.
// The grant is combinational; the pointer advances past each winner.
module rr_arbiter
    import mult_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = MA_NUM_REQ,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en_i,
    input  logic [NUM_REQ-1:0] req_valid_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    grant_idx_o,
    output logic               grant_vld_o
);

    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;

    // Cyclic search starting at ptr; the first valid requester wins.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        grant_vld_o = 1'b0;
        sum         = '0;
        idx         = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            sum = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(NUM_REQ)) begin
                sum = sum - (ID_W+1)'(NUM_REQ);
            end
            idx = sum[ID_W-1:0];
            if (!grant_vld_o && en_i && !reset && req_valid_i[idx]) begin
                grant_vld_o   = 1'b1;
                grant_o[idx]  = 1'b1;
                grant_idx_o   = idx;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_vld_o) begin
            ptr_d = (grant_idx_o == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mult_share_arb.sv
// Shares one pipelined multiplier among NUM_REQ requesters: arbitrates, registers
// the winning operands and tags each result with its owner through a shift pipe.
module mult_share_arb
    import mult_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = MA_NUM_REQ,
    parameter int unsigned DATA_W  = MA_DATA_W,
    parameter int unsigned MUL_LAT = MA_MUL_LAT,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_m,
    input  logic [NUM_REQ*DATA_W-1:0] req_r,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         mul_m,
    output logic [DATA_W-1:0]         mul_r,
    input  logic [DATA_W-1:0]         mul_product,
    output logic                      resp_valid,
    output logic [ID_W-1:0]           resp_id,
    output logic [DATA_W-1:0]         resp_product,
    output logic                      busy
);

    localparam int unsigned PipeD = 1 + MUL_LAT;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_vld;

    logic [DATA_W-1:0]  m_slice [NUM_REQ];
    logic [DATA_W-1:0]  r_slice [NUM_REQ];
    logic [DATA_W-1:0]  mul_m_q, mul_m_d;
    logic [DATA_W-1:0]  mul_r_q, mul_r_d;

    logic [PipeD-1:0]   pipe_vld_q, pipe_vld_d;
    logic [ID_W-1:0]    pipe_id_q [PipeD];
    logic [ID_W-1:0]    pipe_id_d [PipeD];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk         (clk),
        .reset       (reset),
        .en_i        (en),
        .req_valid_i (req_valid),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .grant_vld_o (grant_vld)
    );

    always_comb begin
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            m_slice[i] = req_m[i*DATA_W +: DATA_W];
            r_slice[i] = req_r[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        mul_m_d = mul_m_q;
        mul_r_d = mul_r_q;
        if (grant_vld) begin
            mul_m_d = m_slice[grant_idx];
            mul_r_d = r_slice[grant_idx];
        end
    end

    // Stage 0 lines up with the operand registers; the tail with the product.
    always_comb begin
        pipe_vld_d   = {pipe_vld_q[PipeD-2:0], grant_vld};
        pipe_id_d[0] = grant_vld ? grant_idx : '0;
        for (int i = 1; i < int'(PipeD); i++) begin
            pipe_id_d[i] = pipe_id_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mul_m_q    <= '0;
            mul_r_q    <= '0;
            pipe_vld_q <= '0;
            for (int i = 0; i < int'(PipeD); i++) begin
                pipe_id_q[i] <= '0;
            end
        end else begin
            mul_m_q    <= mul_m_d;
            mul_r_q    <= mul_r_d;
            pipe_vld_q <= pipe_vld_d;
            for (int i = 0; i < int'(PipeD); i++) begin
                pipe_id_q[i] <= pipe_id_d[i];
            end
        end
    end

    // Outputs read as idle while reset is held so no stale response leaks out.
    always_comb begin
        req_ready    = grant;
        mul_m        = mul_m_q;
        mul_r        = mul_r_q;
        resp_valid   = pipe_vld_q[MUL_LAT] & ~reset;
        resp_id      = reset ? '0 : pipe_id_q[MUL_LAT];
        resp_product = mul_product;
        busy         = (|pipe_vld_q) & ~reset;
    end

endmodule
